// File: rtl/sync_add_pkg.sv
// Shared constants for the push-button counter: active-high 7-segment glyphs.
// Bit 0 = segment a ... bit 6 = segment g.
package sync_add_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Hex glyphs 0-9, A, b, C, d, E, F
  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/sync_add_seg7_decode.sv
// Hex digit to active-high 7-segment pattern, purely combinational.
module seg7_decode
  import sync_add_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    seg = SEG7_HEX[digit];
  end

endmodule

// File: rtl/sync_add.sv
// Synchronous modulo-(MAX+1) push-button up counter with carry and registered 7-segment drive.
// Optional SYNC_ADD_SAT_EN: saturate at MAX instead of wrapping.
module sync_add
  import sync_add_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic [6:0]       leds
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic       s1, s2, s3;
  logic       sync_live;
  logic       inc;
  logic [3:0] digit;
  logic [6:0] seg_on;

  // The first edge after reset loads the whole chain with the current level,
  // so a button held through reset release never looks like a rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      sync_live <= 1'b0;
    end else if (!sync_live) begin
      s1        <= step;
      s2        <= step;
      s3        <= step;
      sync_live <= 1'b1;
    end else begin
      s1 <= step;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign inc = s2 & ~s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      carry <= 1'b0;
    end else if (clr) begin
      count <= '0;
      carry <= 1'b0;
    end else if (inc && en && count == MAX_V) begin
`ifdef SYNC_ADD_SAT_EN
      count <= count;
      carry <= 1'b0;
`else
      count <= '0;
      carry <= 1'b1;
`endif
    end else if (inc && en) begin
      count <= count + WIDTH'(1);
      carry <= 1'b0;
    end else begin
      carry <= 1'b0;
    end
  end

  assign digit = 4'(count);

  seg7_decode u_seg7 (
    .digit (digit),
    .seg   (seg_on)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) leds <= 7'b1000000;
    else        leds <= ~seg_on;
  end

endmodule

// File: tb/tb_sync_add.sv
// Bench for sync_add: two instances (MAX=15 and MAX=9) against a sample-history model.
module tb_sync_add;

  logic       clk = 1'b0;
  logic       reset, step, en, clr;
  logic [3:0] count, count9;
  logic       carry, carry9;
  logic [6:0] leds, leds9;

  int n_chk  = 0;
  int n_fail = 0;
  int c15 = 0;
  int c9  = 0;

  always #5 clk = ~clk;

  sync_add #(.WIDTH(4), .MAX(15)) dut (
    .clk(clk), .reset(reset), .step(step), .en(en), .clr(clr),
    .count(count), .carry(carry), .leds(leds)
  );

  sync_add #(.WIDTH(4), .MAX(9)) dut9 (
    .clk(clk), .reset(reset), .step(step), .en(en), .clr(clr),
    .count(count9), .carry(carry9), .leds(leds9)
  );

  // Active-low glyphs written out independently of the design package
  localparam logic [6:0] LED_LO [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] next_state(logic [3:0] c, int mx, bit inc, bit e, bit cl);
    if (cl) return 5'd0;
    if (!(inc && e)) return {1'b0, c};
    if (int'(c) == mx) begin
`ifdef SYNC_ADD_SAT_EN
      return {1'b0, c};
`else
      return 5'b10000;
`endif
    end
    return {1'b0, c + 4'd1};
  endfunction

  // Model: step samples at each edge; an increment request exists at edge n
  // when the sample of edge n-2 is high and that of edge n-3 is low.
  bit         smp[$];
  bit         m_init;
  bit         m_inc;
  logic [3:0] m15_cnt, m9_cnt;
  logic       m15_cy, m9_cy;
  logic [6:0] m15_led, m9_led;
  logic [4:0] nx;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp.delete();
      m_init  = 1'b0;
      m15_cnt = 4'd0; m15_cy = 1'b0; m15_led = 7'b1000000;
      m9_cnt  = 4'd0; m9_cy  = 1'b0; m9_led  = 7'b1000000;
    end else begin
      m_inc   = m_init && smp[$-1] && !smp[$-2];
      m15_led = LED_LO[m15_cnt];
      m9_led  = LED_LO[m9_cnt];
      nx = next_state(m15_cnt, 15, m_inc, en, clr);
      {m15_cy, m15_cnt} = nx;
      nx = next_state(m9_cnt, 9, m_inc, en, clr);
      {m9_cy, m9_cnt} = nx;
      if (!m_init) begin
        repeat (3) smp.push_back(step);
        m_init = 1'b1;
      end else begin
        smp.push_back(step);
      end
      if (smp.size() > 8) void'(smp.pop_front());
    end
  end

  always @(negedge clk) begin
    check("count",  32'(count),  32'(m15_cnt));
    check("carry",  32'(carry),  32'(m15_cy));
    check("leds",   32'(leds),   32'(m15_led));
    check("count9", 32'(count9), 32'(m9_cnt));
    check("carry9", 32'(carry9), 32'(m9_cy));
    check("leds9",  32'(leds9),  32'(m9_led));
    if (carry)  c15++;
    if (carry9) c9++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    step = 1'b1;
    repeat (hi) tick();
    step = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0; step = 1'b0; en = 1'b1; clr = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_leds",  32'(leds),  32'(7'b1000000));

    // Single step: count moves at the 3rd edge after the rise, leds one later
    step = 1'b1;
    tick();
    tick();
    check("step_e2_count", 32'(count), 32'd0);
    tick();
    check("step_e3_count", 32'(count), 32'd1);
    check("step_e3_leds",  32'(leds),  32'(7'b1000000));
    tick();
    check("step_e4_leds",  32'(leds),  32'(7'b1111001));
    step = 1'b0;
    repeat (4) tick();

    // Wrap on the MAX=9 instance
    do_clr();
    c9 = 0;
    for (int i = 0; i < 10; i++) begin
      pulse(4, 4);
`ifdef SYNC_ADD_SAT_EN
      check("wrap9_count", 32'(count9), (i + 1 > 9) ? 32'd9 : 32'(i + 1));
`else
      check("wrap9_count", 32'(count9), 32'((i + 1) % 10));
`endif
    end
`ifdef SYNC_ADD_SAT_EN
    check("wrap9_carries", 32'(c9), 32'd0);
`else
    check("wrap9_carries", 32'(c9), 32'd1);
`endif
    check("wrap_count15", 32'(count), 32'd10);

    // Increment requests while disabled are dropped
    en = 1'b0;
    repeat (3) pulse(4, 4);
    check("en_off_count", 32'(count), 32'd10);
    en = 1'b1;

    // Clear coincident with an increment at count 7
    do_clr();
    repeat (7) pulse(3, 3);
    check("pre_clr_count", 32'(count), 32'd7);
    step = 1'b1;
    tick();
    tick();
    clr = 1'b1;
    tick();
    check("clr_inc_count", 32'(count), 32'd0);
    check("clr_inc_carry", 32'(carry), 32'd0);
    clr = 1'b0;
    step = 1'b0;
    repeat (4) tick();
    check("clr_inc_after", 32'(count), 32'd0);

    // Held button gives one increment
    step = 1'b1;
    repeat (50) tick();
    step = 1'b0;
    repeat (4) tick();
    check("held_count", 32'(count), 32'd1);

    // Twenty presses on MAX=15
    do_clr();
    c15 = 0;
    repeat (20) pulse(3, 3);
    repeat (3) tick();
`ifdef SYNC_ADD_SAT_EN
    check("twenty_count",   32'(count), 32'd15);
    check("twenty_carries", 32'(c15),   32'd0);
`else
    check("twenty_count",   32'(count), 32'd4);
    check("twenty_carries", 32'(c15),   32'd1);
`endif
    do_clr();
    check("twenty_clr", 32'(count), 32'd0);

    // Reset mid-count, released with the button held
    repeat (5) pulse(3, 3);
    check("pre_rst_count", 32'(count), 32'd5);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_carry", 32'(carry), 32'd0);
    check("midrst_leds",  32'(leds),  32'(7'b1000000));
    step = 1'b1;
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (10) tick();
    check("held_rst_count", 32'(count), 32'd0);
    step = 1'b0;
    repeat (4) tick();
    check("held_rst_fall", 32'(count), 32'd0);
    pulse(3, 3);
    check("post_rst_step", 32'(count), 32'd1);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) step = ~step;
      en  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 40) == 0);
      tick();
    end
    step = 1'b0; en = 1'b1; clr = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
